// File: rtl/sram_bwe_clr.sv
`default_nettype none
// ============================================================================
// Module   : sram_bwe_clr
// Purpose  : Single-port synchronous SRAM with byte write enables and a
//            built-in memory clear. After reset, or on clr_req, every word is
//            written with INIT_VAL, one word per cycle. Accesses that arrive
//            during a clear are rejected and flagged with a one-cycle drop.
//            Read data is registered. A write also returns the word that was
//            stored before the write (read-before-write).
// Ports    : clk      - clock, rising edge
//            rst_n    - asynchronous active-low reset
//            cen      - access enable
//            wen      - byte write enables (DW/8 bits), all zero = read
//            A        - word address
//            D        - write data
//            clr_req  - request a new memory clear (honoured in IDLE only)
//            Q        - registered read data
//            ready    - accesses accepted (IDLE)
//            drop     - pulse one cycle after an access rejected during clear
// Revision : 1.0 - initial release
// ============================================================================
module sram_bwe_clr #(
  parameter int              DW       = 32,
  parameter int              AW       = 13,
  parameter logic [DW-1:0]   INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cen,
  input  logic [DW/8-1:0]   wen,
  input  logic [AW-1:0]     A,
  input  logic [DW-1:0]     D,
  input  logic              clr_req,
  output logic [DW-1:0]     Q,
  output logic              ready,
  output logic              drop
);

  localparam int c_NB    = DW / 8;
  localparam int c_DEPTH = 1 << AW;

  typedef enum logic [0:0] {
    S_CLEAR = 1'b0,
    S_IDLE  = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [AW-1:0]   r_cnt;
  logic [DW-1:0]   r_mem [c_DEPTH];
  logic [DW-1:0]   r_q;
  logic            r_drop;
  logic            w_last;
  logic            w_acc;

  // The clear ends on the cycle that writes the top address.
  assign w_last = &r_cnt;
  assign w_acc  = cen && (r_state == S_IDLE);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_CLEAR: if (w_last)  w_state_nxt = S_IDLE;
      S_IDLE:  if (clr_req) w_state_nxt = S_CLEAR;
      default: w_state_nxt = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_CLEAR;
      r_cnt   <= '0;
      r_q     <= '0;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      // Counter is parked at zero in IDLE so a new clear always starts at 0.
      r_cnt   <= (r_state == S_CLEAR) ? r_cnt + 1'b1 : '0;
      r_drop  <= cen && (r_state == S_CLEAR);
      // Reads and writes both load Q with the stored (pre-write) word.
      if (w_acc) r_q <= r_mem[A];
    end
  end

  // Array has no reset; rst_n only blocks writes while it is held low.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (r_state == S_CLEAR) begin
        r_mem[r_cnt] <= INIT_VAL;
      end else if (cen) begin
        for (int i = 0; i < c_NB; i++) begin
          if (wen[i]) r_mem[A][8*i +: 8] <= D[8*i +: 8];
        end
      end
    end
  end

  assign Q     = r_q;
  assign ready = (r_state == S_IDLE);
  assign drop  = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_sram_bwe_clr.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_bwe_clr
// Purpose  : Self-checking bench for sram_bwe_clr (DW=32, AW=4,
//            INIT_VAL=A5A5A5A5). A behavioural model holds the memory as an
//            array plus a "clear in progress / words cleared so far" status;
//            every clock edge the DUT outputs are compared with the model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_bwe_clr;

  localparam int          DW    = 32;
  localparam int          AW    = 4;
  localparam int          DEPTH = 16;
  localparam logic [31:0] IV    = 32'hA5A5A5A5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cen;
  logic [3:0]  wen;
  logic [3:0]  A;
  logic [31:0] D;
  logic        clr_req;
  logic [31:0] Q;
  logic        ready;
  logic        drop;

  int checks   = 0;
  int failures = 0;

  // reference model
  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_q;
  logic        m_drop;
  bit          m_clearing;
  int          m_done;       // words cleared so far in the current clear

  sram_bwe_clr #(.DW(DW), .AW(AW), .INIT_VAL(IV)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .wen(wen), .A(A), .D(D),
    .clr_req(clr_req), .Q(Q), .ready(ready), .drop(drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_clearing = 1'b1;
    m_done     = 0;
    m_q        = '0;
    m_drop     = 1'b0;
  endfunction

  // One clock edge of the specified behaviour.
  function automatic void model_edge();
    if (!rst_n) return;
    if (m_clearing) begin
      m_mem[m_done] = IV;
      m_done++;
      m_drop = cen;
      if (m_done == DEPTH) m_clearing = 1'b0;
    end else begin
      m_drop = 1'b0;
      if (cen) begin
        m_q = m_mem[A];
        for (int b = 0; b < 4; b++)
          if (wen[b]) m_mem[A][8*b +: 8] = D[8*b +: 8];
      end
      if (clr_req) begin
        m_clearing = 1'b1;
        m_done     = 0;
      end
    end
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("ready", {31'd0, ready}, {31'd0, !m_clearing});
    check("drop",  {31'd0, drop},  {31'd0, m_drop});
    check("Q",     Q,              m_q);
  endtask

  task automatic idle_in();
    cen = 0; wen = 0; A = 0; D = 0; clr_req = 0;
  endtask

  // Step until ready, bounded; returns edges taken (or -1 on timeout).
  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 40) begin step(); n++; end
    if (!ready) begin
      $display("FAIL wait_ready: got timeout expected ready within 40 cycles");
      failures++; checks++;
      n = -1;
    end
  endtask

  initial begin
    int n;
    idle_in();
    rst_n = 1'b0;
    model_reset();
    #12;
    check("rst_Q",     Q,                32'h0);
    check("rst_ready", {31'd0, ready},   32'h0);
    check("rst_drop",  {31'd0, drop},    32'h0);

    // ---- power-up clear: ready 16 cycles after release
    @(negedge clk); rst_n = 1'b1;
    wait_ready(n);
    check("pwrup_clear_len", n, 16);

    for (int a = 0; a < DEPTH; a++) begin
      cen = 1; A = a[3:0]; step();
      check("init_read", Q, IV);
    end

    // ---- partial-byte write with read-before-write
    cen = 1; A = 3; D = 32'h11223344; wen = 4'b0101; step();
    check("rbw_old", Q, IV);
    wen = 0; step();
    check("bwe_read", Q, 32'hA522A544);

    // ---- full write, read, hold while idle
    A = 7; D = 32'hDEADBEEF; wen = 4'hF; step();
    wen = 0; step();
    check("full_read", Q, 32'hDEADBEEF);
    cen = 0; A = 3; repeat (3) step();
    check("q_hold", Q, 32'hDEADBEEF);

    // ---- clr_req with a same-cycle write; drop at cycle 5; clr_req at 4 ignored
    cen = 1; A = 2; D = 32'h0; wen = 4'hF; clr_req = 1; step();
    check("clr_wr_oldq", Q, IV);
    idle_in();
    n = 0;
    for (int c = 1; c <= 16; c++) begin
      cen     = (c == 5);
      A       = 4'd9;
      clr_req = (c == 4);
      step();
      if (c == 5) begin
        check("drop_c5", {31'd0, drop}, 32'h1);
        check("drop_q_held", Q, IV);
      end
      if (c < 16 && ready) n++;
    end
    idle_in();
    check("clr_no_early_ready", n, 0);
    check("clr_ready_at16", {31'd0, ready}, 32'h1);
    cen = 1; A = 2; step(); step();
    check("clr_reinit", Q, IV);

    // ---- reset mid-clear (cycle 9) restarts the clear
    idle_in(); clr_req = 1; step(); clr_req = 0;
    repeat (9) step();
    rst_n = 1'b0; model_reset(); #1;
    check("mid_rst_Q",     Q,              32'h0);
    check("mid_rst_ready", {31'd0, ready}, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    wait_ready(n);
    check("restart_clear_len", n, 16);

    // ---- randomized traffic
    for (int i = 0; i < 600; i++) begin
      cen     = ($urandom_range(0, 3) != 0);
      wen     = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
      A       = 4'($urandom);
      D       = $urandom;
      clr_req = ($urandom_range(0, 59) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/sram_bwe_clr.md
SRAM_BWE_CLR -- requirements
Module: sram_bwe_clr

Interface
REQ-001 SHALL have parameter DW, default 32: data width in bits; must be a multiple of 8.
REQ-002 SHALL have parameter AW, default 13: address width; depth = 2^AW words.
REQ-003 SHALL have parameter INIT_VAL, default 0: DW-bit value written to every word during clear.
REQ-004 SHALL have port clk  input  1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1: reset, asynchronous and active-low.
REQ-006 SHALL have port cen  input  1: access enable, active-high.
REQ-007 SHALL have port wen  input  DW/8: byte write enables, active-high; bit i selects D[8i+7:8i].
REQ-008 SHALL have port A  input  AW: word address.
REQ-009 SHALL have port D  input  DW: write data.
REQ-010 SHALL have port clr_req  input  1: request to re-run memory clear.
REQ-011 SHALL have port Q  output  DW: registered read data.
REQ-012 SHALL have port ready  output  1: high when accesses are accepted.
REQ-013 SHALL have port drop  output  1: one-cycle pulse when an access is rejected.

Function
REQ-014 SHALL implement a two-state FSM, CLEAR and IDLE; ready = 1 exactly in IDLE.
REQ-015 CLEAR: an AW-bit counter starts at 0 and writes INIT_VAL to mem[counter] each cycle.
REQ-016 CLEAR exit: after the write to address 2^AW-1, go to IDLE next cycle; clear lasts exactly 2^AW cycles.
REQ-017 Access during CLEAR (cen=1): SHALL NOT be performed; drop pulses high the following cycle; Q unchanged.
REQ-018 Read in IDLE (cen=1, wen=0): Q = mem[A] on the next edge; 1-cycle latency.
REQ-019 Write in IDLE (cen=1, wen!=0): only bytes with wen[i]=1 updated from D; all other bytes keep their previous value.
REQ-020 Write cycles SHALL also load Q with the pre-write (old) word at A (read-before-write).
REQ-021 cen=0 in IDLE: memory unchanged; Q holds its last value.
REQ-022 clr_req=1 in IDLE: enter CLEAR next cycle with counter 0; any access in the same cycle is still performed first.
REQ-023 clr_req during CLEAR: SHALL be ignored; clear is not restarted.
REQ-024 Q SHALL be held, not zeroed, during CLEAR.
REQ-025 drop SHALL be 0 in every cycle other than those specified in REQ-017.

Reset
REQ-026 rst_n low SHALL asynchronously force state CLEAR, counter 0, Q = 0, ready = 0, drop = 0.
REQ-027 Reset asserted mid-clear SHALL restart the clear from address 0 after release.
REQ-028 Memory contents are not reset directly; they are defined only after the clear completes.
REQ-029 No memory write SHALL occur while rst_n is low.

Verification (DW=32, AW=4, INIT_VAL=32'hA5A5A5A5)
REQ-030 Release rst_n -> ready rises exactly 16 cycles later; subsequent reads of addresses 0..15 all return A5A5A5A5.
REQ-031 Write A=3, D=11223344, wen=4'b0101 -> next read of A=3 returns A522A544; the Q sampled on the write cycle is A5A5A5A5.
REQ-032 Write A=7, D=DEADBEEF, wen=F, then read A=7 -> Q=DEADBEEF one cycle after the read; Q holds DEADBEEF while cen=0.
REQ-033 clr_req with write A=2, D=0, wen=F in the same cycle -> write performed, ready=0 for 16 cycles; a read at cycle 5 of the clear gives drop=1 and Q unchanged; afterwards A=2 reads A5A5A5A5.
REQ-034 rst_n pulsed low at clear cycle 9 -> Q=0, ready=0; clear restarts and ready rises 16 cycles after release.
REQ-035 clr_req pulsed at clear cycle 4 -> ignored; ready rises at cycle 16 of the original clear.
